// File: rtl/tiny32_intc_pkg.sv
// tiny32_intc_pkg
//   Shared definitions for the tiny32 interrupt controller.
//   - Word offsets of the four software-visible registers (core address[3:2]).
//   - Upper bound on the number of IRQ lines; the core's interrupt input is 8 bits wide.
package tiny32_intc_pkg;

  localparam int INTC_MAX_IRQ = 8;

  localparam logic [1:0] INTC_PENDING  = 2'd0;
  localparam logic [1:0] INTC_ENABLE   = 2'd1;
  localparam logic [1:0] INTC_MODE     = 2'd2;
  localparam logic [1:0] INTC_POLARITY = 2'd3;

  typedef logic [INTC_MAX_IRQ-1:0] intc_vec_t;

endpackage

// File: rtl/tiny32_intc_line.sv
// tiny32_intc_line
//   One interrupt line of the controller: synchroniser, polarity normalisation,
//   edge history and the PENDING bit.
// Ports
//   clk          clock, posedge
//   nreset       synchronous active-low reset
//   irq_raw      raw asynchronous request from the peripheral
//   mode         1 = edge, 0 = level
//   pol          1 = active-low / falling edge
//   pol_wr       POLARITY register is being written this cycle
//   pol_wdata    new POLARITY bit for this line (valid with pol_wr)
//   w1c          write-1-to-clear for PENDING this cycle
//   pending      registered PENDING bit
//   pending_next value PENDING takes at the next posedge
module tiny32_intc_line
  import tiny32_intc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nreset,
  input  logic irq_raw,
  input  logic mode,
  input  logic pol,
  input  logic pol_wr,
  input  logic pol_wdata,
  input  logic w1c,
  output logic pending,
  output logic pending_next
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   synced;
  logic                   s;
  logic                   rise;

  assign synced = sync_q[SYNC_STAGES-1];
  assign s      = synced ^ pol;
  assign rise   = s & ~hist_q;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw};
    end
  end

  // In edge mode a new edge wins over a simultaneous W1C so no event is lost.
  always_comb begin
    pending_next = s;
    if (mode) begin
      pending_next = (pending & ~w1c) | rise;
    end
  end

  // History tracks s in both modes, so switching level->edge starts with
  // hist = s. On a polarity write it takes the value s will have under the
  // new polarity, which suppresses a spurious edge.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      pending <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      pending <= pending_next;
      hist_q  <= pol_wr ? (synced ^ pol_wdata) : s;
    end
  end

endmodule

// File: rtl/tiny32_intc.sv
// tiny32_intc
//   Memory-mapped interrupt controller driving the tiny32 core's interrupt[7:0].
//   4-word slave: PENDING (R/W1C), ENABLE, MODE (1=edge), POLARITY (1=active-low).
// Ports
//   clk        clock, posedge
//   nreset     synchronous active-low reset
//   irq_in     raw asynchronous peripheral requests
//   sel        slave select (decoded externally)
//   reg_addr   word select, core address[3:2]
//   nrd        active-low read strobe
//   nwr        active-low byte-lane write strobes; only lane 0 is used
//   data_in    write data
//   data_out   read data
//   ready      low inserts a wait state on reads
//   interrupt  PENDING & ENABLE, registered; bits >= NUM_IRQ are 0
module tiny32_intc
  import tiny32_intc_pkg::*;
#(
  parameter int NUM_IRQ     = 8,
  parameter int SYNC_STAGES = 2,
  parameter int READ_WAIT   = 0
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               sel,
  input  logic [1:0]         reg_addr,
  input  logic               nrd,
  input  logic [3:0]         nwr,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  output logic               ready,
  output logic [7:0]         interrupt
);

  localparam logic [1:0] WAIT_CYCLES = 2'(READ_WAIT);

  logic               rd_active;
  logic               wr_active;
  logic               wr_pending;
  logic               wr_enable;
  logic               wr_mode;
  logic               wr_pol;
  logic [NUM_IRQ-1:0] wdata;
  logic [NUM_IRQ-1:0] enable_q;
  logic [NUM_IRQ-1:0] mode_q;
  logic [NUM_IRQ-1:0] pol_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] pending_next;
  logic [31:0]        rd_mux;
  logic [31:0]        data_q;
  logic [1:0]         wait_cnt;
  logic [7:0]         irq_next;
  logic [7:0]         interrupt_q;
  logic               unused_bits;

  assign rd_active  = sel & ~nrd;
  assign wr_active  = sel & ~nwr[0];
  assign wdata      = data_in[NUM_IRQ-1:0];
  assign wr_pending = wr_active && (reg_addr == INTC_PENDING);
  assign wr_enable  = wr_active && (reg_addr == INTC_ENABLE);
  assign wr_mode    = wr_active && (reg_addr == INTC_MODE);
  assign wr_pol     = wr_active && (reg_addr == INTC_POLARITY);

  assign unused_bits = ^{data_in[31:NUM_IRQ], nwr[3:1]};

  always_ff @(posedge clk) begin
    if (!nreset) begin
      enable_q <= '0;
      mode_q   <= '0;
      pol_q    <= '0;
    end else begin
      if (wr_enable) enable_q <= wdata;
      if (wr_mode)   mode_q   <= wdata;
      if (wr_pol)    pol_q    <= wdata;
    end
  end

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    tiny32_intc_line #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_line (
      .clk         (clk),
      .nreset      (nreset),
      .irq_raw     (irq_in[i]),
      .mode        (mode_q[i]),
      .pol         (pol_q[i]),
      .pol_wr      (wr_pol),
      .pol_wdata   (wdata[i]),
      .w1c         (wr_pending & wdata[i]),
      .pending     (pending_q[i]),
      .pending_next(pending_next[i])
    );
  end

  // Read mux works on the current register values, so a read that
  // coincides with a write to the same word sees the pre-write value.
  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      INTC_PENDING:  rd_mux[NUM_IRQ-1:0] = pending_q;
      INTC_ENABLE:   rd_mux[NUM_IRQ-1:0] = enable_q;
      INTC_MODE:     rd_mux[NUM_IRQ-1:0] = mode_q;
      default:       rd_mux[NUM_IRQ-1:0] = pol_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      data_q <= '0;
    end else if (rd_active) begin
      data_q <= rd_mux;
    end
  end

  // Wait counter restarts whenever the read strobe or select drops.
  always_ff @(posedge clk) begin
    if (!nreset || !rd_active) begin
      wait_cnt <= '0;
    end else if (wait_cnt < WAIT_CYCLES) begin
      wait_cnt <= wait_cnt + 2'd1;
    end
  end

  // Reset is folded into the combinational outputs so an access in flight
  // during reset sees ready=1 and data_out=0.
  assign ready    = !(nreset && rd_active && (wait_cnt < WAIT_CYCLES));
  assign data_out = (READ_WAIT == 0 && nreset && rd_active) ? rd_mux : data_q;

  // Registering next-state PENDING keeps irq_in->interrupt at SYNC_STAGES+1
  // clocks; an ENABLE change shows one clock after the register updates.
  always_comb begin
    irq_next = '0;
    irq_next[NUM_IRQ-1:0] = pending_next & enable_q;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      interrupt_q <= '0;
    end else begin
      interrupt_q <= irq_next;
    end
  end

  assign interrupt = interrupt_q;

endmodule
